// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM-style pipeline control registers.
//   cond_e      : ARM condition field encoding
//   ctrl_t      : per-instruction control bundle carried D->E
//   CTRL_BUBBLE : control value of an inserted bubble (all off, Cond=AL)
package arm_pipe_pkg;

    localparam int unsigned COND_W = 4;
    localparam int unsigned NZCV_W = 4;

    typedef enum logic [COND_W-1:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic  RegWrite;
        logic  MemtoReg;
        logic  MemWrite;
        logic  PCSrc;
        logic  Branch;
        logic  FlagWrite;
        cond_e Cond;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        RegWrite:  1'b0,
        MemtoReg:  1'b0,
        MemWrite:  1'b0,
        PCSrc:     1'b0,
        Branch:    1'b0,
        FlagWrite: 1'b0,
        Cond:      AL
    };

endpackage

// File: rtl/pipe_ctrl_regs_cond_unit.sv
// Combinational ARM condition evaluator.
//   cond    in  : condition field of the E-stage instruction
//   flags   in  : architectural NZCV (N=bit3, Z=bit2, C=bit1, V=bit0)
//   cond_ex out : 1 when the instruction is allowed to take effect
module cond_unit
    import arm_pipe_pkg::*;
(
    input  cond_e             cond,
    input  logic [NZCV_W-1:0] flags,
    output logic              cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            // NV is unpredictable on this core; treat it as never-execute
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Pipeline registers D->E->M->WB feeding the hazard unit.
//   clk, reset                : clock, synchronous active-high reset
//   StallF, StallD, FlushD    : IF/ID hold / kill controls (StallF unused here)
//   FlushE                    : turn the ID/EX register into a bubble
//   InstrF / InstrD           : fetched / IF/ID instruction
//   ra1D, ra2D, wa3D, *D      : decoded addresses and controls
//   CondD, ALUFlagsE          : condition field, ALU NZCV from E
//   ra1E..wa3WB, *E/*M/*WB    : stage fields consumed by the hazard unit
//   FlagsE                    : architectural NZCV register
module pipe_ctrl_regs
    import arm_pipe_pkg::*;
#(
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned RA_W      = 4,
    parameter logic [3:0]  FLAGS_RST = 4'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               FlushE,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [INSTR_W-1:0] InstrD,
    input  logic [RA_W-1:0]    ra1D,
    input  logic [RA_W-1:0]    ra2D,
    input  logic [RA_W-1:0]    wa3D,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic               PCSrcD,
    input  logic               BranchD,
    input  logic               FlagWriteD,
    input  logic [3:0]         CondD,
    input  logic [3:0]         ALUFlagsE,
    output logic [RA_W-1:0]    ra1E,
    output logic [RA_W-1:0]    ra2E,
    output logic [RA_W-1:0]    wa3E,
    output logic               MemtoRegE,
    output logic               PCSrcE,
    output logic               BranchTakenE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               MemtoRegM,
    output logic               PCSrcM,
    output logic [RA_W-1:0]    wa3M,
    output logic               RegWriteWB,
    output logic               MemtoRegWB,
    output logic               PCSrcWB,
    output logic [RA_W-1:0]    wa3WB,
    output logic [3:0]         FlagsE
);

    // No PC lives in this block, so the fetch stall has nothing to gate
    logic unused_stall_f;
    assign unused_stall_f = StallF;

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    logic  cond_ex_e;

    assign ctrl_d = '{
        RegWrite:  RegWriteD,
        MemtoReg:  MemtoRegD,
        MemWrite:  MemWriteD,
        PCSrc:     PCSrcD,
        Branch:    BranchD,
        FlagWrite: FlagWriteD,
        Cond:      cond_e'(CondD)
    };

    // IF/ID: flush wins over stall so a wrong-path instruction is always killed
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD <= '0;
        end else if (!StallD) begin
            InstrD <= InstrF;
        end
    end

    // ID/EX: never stalled; load-use hazards arrive here as FlushE
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ctrl_e <= CTRL_BUBBLE;
            ra1E   <= '0;
            ra2E   <= '0;
            wa3E   <= '0;
        end else begin
            ctrl_e <= ctrl_d;
            ra1E   <= ra1D;
            ra2E   <= ra2D;
            wa3E   <= wa3D;
        end
    end

    cond_unit u_cond (
        .cond    (ctrl_e.Cond),
        .flags   (FlagsE),
        .cond_ex (cond_ex_e)
    );

    // MemtoRegE stays ungated: a spurious load-use stall is harmless
    assign MemtoRegE    = ctrl_e.MemtoReg;
    assign PCSrcE       = ctrl_e.PCSrc  & cond_ex_e;
    assign BranchTakenE = ctrl_e.Branch & cond_ex_e;

    // NZCV updates only for flag-setting instructions that pass their condition
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsE <= FLAGS_RST;
        end else if (ctrl_e.FlagWrite && cond_ex_e) begin
            FlagsE <= ALUFlagsE;
        end
    end

    // EX/MEM: side effects are squashed here when the condition fails
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            PCSrcM    <= 1'b0;
            wa3M      <= '0;
        end else begin
            RegWriteM <= ctrl_e.RegWrite & cond_ex_e;
            MemWriteM <= ctrl_e.MemWrite & cond_ex_e;
            MemtoRegM <= ctrl_e.MemtoReg;
            PCSrcM    <= PCSrcE;
            wa3M      <= wa3E;
        end
    end

    // MEM/WB
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteWB <= 1'b0;
            MemtoRegWB <= 1'b0;
            PCSrcWB    <= 1'b0;
            wa3WB      <= '0;
        end else begin
            RegWriteWB <= RegWriteM;
            MemtoRegWB <= MemtoRegM;
            PCSrcWB    <= PCSrcM;
            wa3WB      <= wa3M;
        end
    end

endmodule
